fft8_input_loader: RTL and testbench

Serial-to-parallel front end for the 8-point FFT datapath. It accepts a stream of real 16-bit samples over a valid/ready handshake and assembles them into 8-sample frames. Completed frames are presented as held parallel words x_0_re..x_7_re, with a frame_valid/frame_ready handshake, to the stage-I butterflies.
Frame collection is double-buffered, so frame n+1 fills while frame n is held at the outputs.

---
 rtl/fft8_pkg.sv | 12 +
 rtl/fft8_frame_buf.sv | 23 ++
 rtl/fft8_input_loader.sv | 111 +++++++++++
 tb/tb_fft8_input_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants and loader state encoding for the 8-point FFT front end.
package fft8_pkg;

  localparam int DATA_W = 16;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = 3;

  typedef logic [0:0] loader_state_t;
  localparam loader_state_t COLLECT = 1'b0;
  localparam loader_state_t HOLD    = 1'b1;

endpackage

// File: rtl/fft8_frame_buf.sv
// 8-entry sample register file with indexed write; all entries visible in parallel.
module fft8_frame_buf #(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      we,
  input  logic [fft8_pkg::IDX_W-1:0]                wr_idx,
  input  logic [DATA_W-1:0]                         wr_data,
  output logic [fft8_pkg::N_PTS-1:0][DATA_W-1:0]    rd_data
);
  import fft8_pkg::*;

  // NOTE: the buffer is flop-based and read in parallel, so it gets a real reset; a RAM macro would not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (we) begin
      rd_data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/fft8_input_loader.sv
// Serial-to-parallel loader: collects 8 samples, double-buffers against a held output frame.
module fft8_input_loader #(
  parameter int DATA_W = fft8_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] x_0_re,
  output logic [DATA_W-1:0] x_1_re,
  output logic [DATA_W-1:0] x_2_re,
  output logic [DATA_W-1:0] x_3_re,
  output logic [DATA_W-1:0] x_4_re,
  output logic [DATA_W-1:0] x_5_re,
  output logic [DATA_W-1:0] x_6_re,
  output logic [DATA_W-1:0] x_7_re,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [CNT_W-1:0]  frame_cnt
);
  import fft8_pkg::*;

  loader_state_t                   state;
  logic [IDX_W-1:0]                wr_idx;
  logic [N_PTS-1:0][DATA_W-1:0]    coll_buf;
  logic [N_PTS-1:0][DATA_W-1:0]    frame_d;
  logic [N_PTS-1:0][DATA_W-1:0]    x_q;

  logic accept;
  logic slot_free;
  logic last_accept;
  logic xfer_direct;
  logic xfer_hold;
  logic transfer;
  logic buf_we;

  assign s_ready     = (state == COLLECT);
  assign accept      = s_valid && s_ready;
  assign slot_free   = !frame_valid || frame_ready;
  assign last_accept = accept && (wr_idx == IDX_W'(N_PTS - 1));
  // The 8th sample bypasses the buffer when the output slot can take it on the same edge.
  assign xfer_direct = !flush && last_accept && slot_free;
  assign xfer_hold   = !flush && (state == HOLD) && slot_free;
  assign transfer    = xfer_direct || xfer_hold;
  assign buf_we      = accept && !flush;

  fft8_frame_buf #(.DATA_W(DATA_W)) u_frame_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_data (coll_buf)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    frame_d = coll_buf;
    if (xfer_direct) begin
      frame_d[N_PTS-1] = s_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= COLLECT;
      wr_idx <= '0;
    end else if (flush) begin
      state  <= COLLECT;
      wr_idx <= '0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
      end
      case (state)
        COLLECT: if (last_accept && !slot_free) state <= HOLD;
        HOLD:    if (slot_free)                 state <= COLLECT;
        default:                                state <= COLLECT;
      endcase
    end
  end

  // Output slot is untouched by flush; only a transfer replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else if (transfer) begin
      x_q         <= frame_d;
      frame_valid <= 1'b1;
      frame_cnt   <= frame_cnt + 1'b1;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  assign x_0_re = x_q[0];
  assign x_1_re = x_q[1];
  assign x_2_re = x_q[2];
  assign x_3_re = x_q[3];
  assign x_4_re = x_q[4];
  assign x_5_re = x_q[5];
  assign x_6_re = x_q[6];
  assign x_7_re = x_q[7];

endmodule

// File: tb/tb_fft8_input_loader.sv
// Self-checking bench for fft8_input_loader: directed tables, corner sequences, random vs. frame-level model.
module tb_fft8_input_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] x_0_re, x_1_re, x_2_re, x_3_re, x_4_re, x_5_re, x_6_re, x_7_re;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [7:0]  frame_cnt;

  logic [7:0][15:0] x_out;
  assign x_out = {x_7_re, x_6_re, x_5_re, x_4_re, x_3_re, x_2_re, x_1_re, x_0_re};

  fft8_input_loader #(.DATA_W(16), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .x_0_re      (x_0_re),
    .x_1_re      (x_1_re),
    .x_2_re      (x_2_re),
    .x_3_re      (x_3_re),
    .x_4_re      (x_4_re),
    .x_5_re      (x_5_re),
    .x_6_re      (x_6_re),
    .x_7_re      (x_7_re),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Frame-level reference: partial frame as a queue, one pending frame, one output slot.
  logic [15:0]      q[$];
  bit               pend;
  logic [7:0][15:0] pframe;
  logic [7:0][15:0] mout;
  bit               mfv;
  logic [7:0]       mcnt;

  typedef struct {
    int d;
    bit exp_fv;
    bit exp_ready;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    pend   = 1'b0;
    pframe = '0;
    mout   = '0;
    mfv    = 1'b0;
    mcnt   = '0;
  endfunction

  function automatic void model_update(input bit fl, input bit v, input logic [15:0] d, input bit fr);
    bit sf = !mfv || fr;
    bit x  = 1'b0;
    if (fl) begin
      q.delete();
      pend = 1'b0;
    end else if (pend) begin
      if (sf) begin
        mout = pframe;
        pend = 1'b0;
        x    = 1'b1;
      end
    end else if (v) begin
      q.push_back(d);
      if (q.size() == 8) begin
        if (sf) begin
          for (int i = 0; i < 8; i++) mout[i] = q[i];
          x = 1'b1;
        end else begin
          for (int i = 0; i < 8; i++) pframe[i] = q[i];
          pend = 1'b1;
        end
        q.delete();
      end
    end
    if (x) begin
      mfv  = 1'b1;
      mcnt = mcnt + 8'd1;
    end else if (fr) begin
      mfv = 1'b0;
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 8; i++) check($sformatf("model x_%0d_re", i), x_out[i], mout[i]);
    check("model frame_valid", frame_valid, mfv);
    check("model frame_cnt", frame_cnt, mcnt);
    check("model s_ready", s_ready, !pend);
  endtask

  // Drive one cycle away from the edge, advance both DUT and model, compare after the edge.
  task automatic step(input bit fl, input bit v, input logic [15:0] d, input bit fr);
    flush = fl; s_valid = v; s_data = d; frame_ready = fr;
    #1;
    check("pre-edge s_ready", s_ready, !pend);
    @(posedge clk);
    model_update(fl, v, d, fr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    s_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    for (int i = 0; i < 8; i++) check($sformatf("reset x_%0d_re", i), x_out[i], 16'h0000);
    check("reset frame_valid", frame_valid, 1'b0);
    check("reset frame_cnt", frame_cnt, 8'd0);
    check("reset s_ready", s_ready, 1'b1);
    @(negedge clk) reset_n = 1'b1;

    // Full-rate frame, table-driven.
    tbl[0] = '{501, 1'b0, 1'b1};
    tbl[1] = '{604, 1'b0, 1'b1};
    tbl[2] = '{230, 1'b0, 1'b1};
    tbl[3] = '{-1015, 1'b0, 1'b1};
    tbl[4] = '{2324, 1'b0, 1'b1};
    tbl[5] = '{-304, 1'b0, 1'b1};
    tbl[6] = '{-530, 1'b0, 1'b1};
    tbl[7] = '{1715, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 16'(tbl[i].d), 1'b1);
      check($sformatf("fullrate fv[%0d]", i), frame_valid, tbl[i].exp_fv);
      check($sformatf("fullrate s_ready[%0d]", i), s_ready, tbl[i].exp_ready);
    end
    check("fullrate x_0", x_0_re, 16'd501);
    check("fullrate x_4", x_4_re, 16'd2324);
    check("fullrate x_2", x_2_re, 16'd230);
    check("fullrate x_6", x_6_re, 16'hFDEE);  // -530
    check("fullrate x_3", x_3_re, 16'hFC09);  // -1015
    check("fullrate cnt", frame_cnt, 8'd1);

    // Back-pressure: second frame parks in HOLD until frame_ready.
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
    check("bp s_ready in hold", s_ready, 1'b0);
    check("bp held x_0", x_0_re, 16'd1);
    check("bp held x_7", x_7_re, 16'd8);
    check("bp held cnt", frame_cnt, 8'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("bp x_0", x_0_re, 16'd9);
    check("bp x_7", x_7_re, 16'd16);
    check("bp s_ready", s_ready, 1'b1);
    check("bp cnt", frame_cnt, 8'd2);
    check("bp fv", frame_valid, 1'b1);

    // Sustained: four back-to-back frames at full rate.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b1);
      check("sus s_ready", s_ready, 1'b1);
      if (i % 8 == 7) begin
        check("sus fv pulse", frame_valid, 1'b1);
        check("sus x_0", x_0_re, 16'(i - 7));
      end else begin
        check("sus fv idle", frame_valid, 1'b0);
      end
    end
    check("sus cnt", frame_cnt, 8'd4);

    // Flush coincident with a sample drops it and the partial frame.
    do_reset();
    for (int i = 100; i <= 102; i++) step(1'b0, 1'b1, 16'(i), 1'b1);
    step(1'b1, 1'b1, 16'd103, 1'b1);
    for (int i = 200; i <= 207; i++) step(1'b0, 1'b1, 16'(i), 1'b1);
    check("flush x_0", x_0_re, 16'd200);
    check("flush x_3", x_3_re, 16'd203);
    check("flush x_7", x_7_re, 16'd207);
    check("flush cnt", frame_cnt, 8'd1);

    // Flush while a frame is pending in HOLD drops it even if the slot frees up.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(i + 40), 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    check("holdflush x_0", x_0_re, 16'd40);
    check("holdflush cnt", frame_cnt, 8'd1);
    check("holdflush s_ready", s_ready, 1'b1);

    // Asynchronous reset mid-cycle with a frame held and a partial frame in flight.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i + 10), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(i + 20), 1'b0);
    #2;
    s_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("areset x_%0d_re", i), x_out[i], 16'h0000);
    check("areset fv", frame_valid, 1'b0);
    check("areset cnt", frame_cnt, 8'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i + 30), 1'b1);
    check("areset new x_0", x_0_re, 16'd30);
    check("areset new x_7", x_7_re, 16'd37);
    check("areset new cnt", frame_cnt, 8'd1);

    // Full-scale extremes pass through bit-exact.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 16'h8000 : 16'h7FFF, 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("fullscale x_%0d_re", i), x_out[i], (i % 2 == 0) ? 16'h8000 : 16'h7FFF);

    // Randomized traffic against the frame-level model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           16'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
